// File: rtl/agc_gain_apply.sv
// agc_gain_apply: closes the AGC gain loop on the EMA level estimate and
// applies the resulting Q2.16 gain to the sample stream (3-stage pipeline).
// Optional feature: define AGC_SAT_CNT_EN to add the sticky 16-bit sat_cnt
// output counting saturated output samples.
module agc_gain_apply #(
  parameter int DWIDTH        = 27,
  parameter int LWIDTH        = 48,
  parameter int GWIDTH        = 18,
  parameter int MUWIDTH       = 18,
  parameter int GAIN_INIT     = 65536,
  parameter int GAIN_MIN      = 1024,
  parameter int GAIN_MAX      = 262143,
  parameter int ERR_SHIFT     = 8,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DWIDTH-1:0]  in_data,
  input  logic [LWIDTH-1:0]  level_in,
  input  logic [LWIDTH-1:0]  target,
  input  logic [MUWIDTH-1:0] mu,
  input  logic               freeze,
  output logic               out_valid,
  output logic [DWIDTH-1:0]  out_data,
  output logic [GWIDTH-1:0]  gain_out,
  output logic [1:0]         state_out
`ifdef AGC_SAT_CNT_EN
  ,
  output logic [15:0]        sat_cnt
`endif
);

  localparam int PWIDTH  = DWIDTH + GWIDTH + 1;   // sample * {0,gain}
  localparam int RWIDTH  = PWIDTH + 1;            // headroom for rounding add
  localparam int QWIDTH  = RWIDTH - 16;           // after dropping Q.16 bits
  localparam int EWIDTH  = LWIDTH + 1;            // signed level error
  localparam int SWIDTH  = 18;                    // saturated error
  localparam int MPWIDTH = MUWIDTH + 1 + SWIDTH;  // mu * err_s
  localparam int DLWIDTH = MPWIDTH - 16;          // gain delta
  localparam int SUMW    = ((GWIDTH + 1 > DLWIDTH) ? GWIDTH + 1 : DLWIDTH) + 1;
  localparam int CW      = $clog2(SETTLE_CYCLES + 1);

  localparam logic signed [RWIDTH-1:0] RND     = RWIDTH'(32768);
  localparam logic signed [QWIDTH-1:0] OUT_MAX = {{(QWIDTH-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [QWIDTH-1:0] OUT_MIN = {{(QWIDTH-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};
  localparam logic signed [EWIDTH-1:0] ERR_MAX = {{(EWIDTH-SWIDTH+1){1'b0}}, {(SWIDTH-1){1'b1}}};
  localparam logic signed [EWIDTH-1:0] ERR_MIN = {{(EWIDTH-SWIDTH+1){1'b1}}, {(SWIDTH-1){1'b0}}};
  localparam logic signed [SUMW-1:0]   SUM_MIN = SUMW'(GAIN_MIN);
  localparam logic signed [SUMW-1:0]   SUM_MAX = SUMW'(GAIN_MAX);
  localparam logic [CW-1:0]            CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    TRACK  = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t                     state;
  logic [CW-1:0]              settle_cnt;
  logic [GWIDTH-1:0]          gain;

  // sample path
  logic                       s1_valid;
  logic signed [DWIDTH-1:0]   s1_data;
  logic [GWIDTH-1:0]          s1_gain;
  logic                       s2_valid;
  logic signed [PWIDTH-1:0]   s2_prod;
  logic signed [RWIDTH-1:0]   s3_round;
  logic signed [QWIDTH-1:0]   s3_shift;
  logic                       s3_hi;
  logic                       s3_lo;
  logic [DWIDTH-1:0]          s3_out;

  // gain path
  logic signed [EWIDTH-1:0]   c1_err;
  logic signed [EWIDTH-1:0]   c1_shift;
  logic signed [SWIDTH-1:0]   c1_errs_next;
  logic                       c1_valid;
  logic signed [SWIDTH-1:0]   c1_errs;
  logic [MUWIDTH-1:0]         c1_mu;
  logic signed [MPWIDTH-1:0]  c2_prod;
  logic signed [DLWIDTH-1:0]  c2_delta_next;
  logic                       c2_valid;
  logic signed [DLWIDTH-1:0]  c2_delta;
  logic signed [SUMW-1:0]     g_sum;
  logic [GWIDTH-1:0]          gain_next;

  assign gain_out  = gain;
  assign state_out = state;

  // Loop state: leave IDLE on first sample, count settle samples, track/hold on freeze.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          if (in_valid) begin
            if (settle_cnt == CNT_LAST) begin
              state      <= TRACK;
              settle_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + CW'(1);
            end
          end
        end
        TRACK:   if (freeze) state <= HOLD;
        HOLD:    if (!freeze) state <= TRACK;
        default: state <= IDLE;
      endcase
    end
  end

  // Sample stages S1/S2: snapshot gain with the sample, then multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_gain  <= '0;
      s2_valid <= 1'b0;
      s2_prod  <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_data  <= in_data;
      s1_gain  <= gain;
      s2_valid <= s1_valid;
      s2_prod  <= PWIDTH'(s1_data) * PWIDTH'($signed({1'b0, s1_gain}));
    end
  end

  // S3 combinational part: round half up, drop fraction, saturate.
  always_comb begin
    s3_round = RWIDTH'(s2_prod) + RND;
    s3_shift = QWIDTH'(s3_round >>> 16);
    s3_hi    = s3_shift > OUT_MAX;
    s3_lo    = s3_shift < OUT_MIN;
    if (s3_hi)      s3_out = {1'b0, {(DWIDTH-1){1'b1}}};
    else if (s3_lo) s3_out = {1'b1, {(DWIDTH-1){1'b0}}};
    else            s3_out = s3_shift[DWIDTH-1:0];
  end

`ifdef AGC_SAT_CNT_EN
  logic s3_sat;
  assign s3_sat = s3_hi | s3_lo;

  // Output register plus sticky count of saturated outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_cnt   <= '0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) out_data <= s3_out;
      if (s2_valid && s3_sat && (sat_cnt != '1)) sat_cnt <= sat_cnt + 16'd1;
    end
  end
`else
  // Output register; out_data holds its last value across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) out_data <= s3_out;
    end
  end
`endif

  // Gain loop arithmetic: error scaling/saturation, mu step, clamped accumulate.
  always_comb begin
    c1_err   = $signed({1'b0, target}) - $signed({1'b0, level_in});
    c1_shift = c1_err >>> ERR_SHIFT;
    if (c1_shift > ERR_MAX)      c1_errs_next = {1'b0, {(SWIDTH-1){1'b1}}};
    else if (c1_shift < ERR_MIN) c1_errs_next = {1'b1, {(SWIDTH-1){1'b0}}};
    else                         c1_errs_next = c1_shift[SWIDTH-1:0];

    c2_prod       = MPWIDTH'($signed({1'b0, c1_mu})) * MPWIDTH'(c1_errs);
    c2_delta_next = DLWIDTH'(c2_prod >>> 16);

    g_sum = SUMW'($signed({1'b0, gain})) + SUMW'(c2_delta);
    if (g_sum > SUM_MAX)      gain_next = GWIDTH'(GAIN_MAX);
    else if (g_sum < SUM_MIN) gain_next = GWIDTH'(GAIN_MIN);
    else                      gain_next = g_sum[GWIDTH-1:0];
  end

  // Gain pipeline C1/C2/C3; freeze flushes in-flight updates and holds gain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c1_valid <= 1'b0;
      c1_errs  <= '0;
      c1_mu    <= '0;
      c2_valid <= 1'b0;
      c2_delta <= '0;
      gain     <= GWIDTH'(GAIN_INIT);
    end else begin
      c1_valid <= in_valid && (state == TRACK) && !freeze;
      c1_errs  <= c1_errs_next;
      c1_mu    <= mu;
      c2_valid <= c1_valid && !freeze;
      c2_delta <= c2_delta_next;
      if (c2_valid && !freeze) gain <= gain_next;
    end
  end

endmodule
